// File: rtl/rst_seq.sv
`default_nettype none
// ============================================================================
// Module      : rst_seq
// Description : Multi-channel reset sequencer. Filters PLL lock, then releases
//               CHANNELS active-high resets in order, each after a settle delay
//               and gated on the previous stage's acknowledge, with a per-stage
//               acknowledge timeout that latches a sticky fault.
// Revision    : 1.0 - initial release
// ============================================================================
module rst_seq #(
  parameter int CHANNELS    = 4,
  parameter int DELAY       = 1024,
  parameter int TIMEOUT     = 65536,
  parameter int LOCK_FILTER = 256,
  localparam int MAX_DT     = (DELAY > TIMEOUT) ? DELAY : TIMEOUT,
  localparam int MAX_ALL    = (MAX_DT > LOCK_FILTER) ? MAX_DT : LOCK_FILTER,
  localparam int CW         = $clog2(MAX_ALL + 1),
  localparam int SW         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                pll_locked,
  input  logic [CHANNELS-1:0] stage_ok,
  input  logic                sw_reset,
  output logic [CHANNELS-1:0] rst_out,
  output logic                all_ready,
  output logic                error,
  output logic [SW-1:0]       fault_stage
);

  typedef enum logic [1:0] {
    LOCK_WAIT = 2'd0,
    STAGE     = 2'd1,
    RUN       = 2'd2,
    FAULT     = 2'd3
  } state_t;

  localparam logic [CW-1:0]       LOCK_LAST    = CW'(LOCK_FILTER - 1);
  localparam logic [CW-1:0]       DELAY_LAST   = CW'(DELAY - 1);
  localparam logic [CW-1:0]       TIMEOUT_LAST = CW'(TIMEOUT - 1);
  localparam logic [SW-1:0]       LAST_STAGE   = SW'(CHANNELS - 1);
  localparam logic [CHANNELS-1:0] ALL_ON       = {CHANNELS{1'b1}};

  logic [1:0]          sync_q, sync_d;
  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [SW-1:0]       s_q, s_d;
  logic                released_q, released_d;
  logic [CHANNELS-1:0] rst_out_q, rst_out_d;
  logic                all_ready_q, all_ready_d;
  logic                error_q, error_d;
  logic [SW-1:0]       fault_stage_q, fault_stage_d;
  logic                lock_s;

  assign sync_d = {sync_q[0], pll_locked};
  assign lock_s = sync_q[1];

  // Two-flop synchroniser for the asynchronous PLL lock indication.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b00;
    else        sync_q <= sync_d;
  end

  // Next-state logic: aborts (sw_reset, then lock loss) take priority over
  // every state action, including a release or advance due this cycle.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    s_d           = s_q;
    released_d    = released_q;
    rst_out_d     = rst_out_q;
    all_ready_d   = all_ready_q;
    error_d       = error_q;
    fault_stage_d = fault_stage_q;
    if (sw_reset) begin
      state_d       = LOCK_WAIT;
      cnt_d         = '0;
      s_d           = '0;
      released_d    = 1'b0;
      rst_out_d     = ALL_ON;
      all_ready_d   = 1'b0;
      error_d       = 1'b0;
      fault_stage_d = '0;
    end else if (!lock_s && (state_q == STAGE || state_q == RUN)) begin
      state_d     = LOCK_WAIT;
      cnt_d       = '0;
      s_d         = '0;
      released_d  = 1'b0;
      rst_out_d   = ALL_ON;
      all_ready_d = 1'b0;
    end else begin
      case (state_q)
        LOCK_WAIT: begin
          rst_out_d   = ALL_ON;
          all_ready_d = 1'b0;
          if (!lock_s) begin
            cnt_d = '0;
          end else if (cnt_q == LOCK_LAST) begin
            state_d    = STAGE;
            cnt_d      = '0;
            s_d        = '0;
            released_d = 1'b0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        STAGE: begin
          if (!released_q) begin
            if (cnt_q == DELAY_LAST) begin
              rst_out_d[s_q] = 1'b0;
              released_d     = 1'b1;
              cnt_d          = '0;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end else if (stage_ok[s_q]) begin
            if (s_q == LAST_STAGE) begin
              state_d     = RUN;
              all_ready_d = 1'b1;
              rst_out_d   = '0;
            end else begin
              s_d        = s_q + SW'(1);
              cnt_d      = '0;
              released_d = 1'b0;
            end
          end else if (cnt_q == TIMEOUT_LAST) begin
            state_d       = FAULT;
            error_d       = 1'b1;
            fault_stage_d = s_q;
            rst_out_d     = ALL_ON;
            all_ready_d   = 1'b0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        RUN: begin
          all_ready_d = 1'b1;
          rst_out_d   = '0;
        end
        FAULT: begin
          all_ready_d = 1'b0;
          rst_out_d   = ALL_ON;
        end
        default: begin
          state_d   = LOCK_WAIT;
          cnt_d     = '0;
          rst_out_d = ALL_ON;
        end
      endcase
    end
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= LOCK_WAIT;
      cnt_q         <= '0;
      s_q           <= '0;
      released_q    <= 1'b0;
      rst_out_q     <= ALL_ON;
      all_ready_q   <= 1'b0;
      error_q       <= 1'b0;
      fault_stage_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      s_q           <= s_d;
      released_q    <= released_d;
      rst_out_q     <= rst_out_d;
      all_ready_q   <= all_ready_d;
      error_q       <= error_d;
      fault_stage_q <= fault_stage_d;
    end
  end

  assign rst_out     = rst_out_q;
  assign all_ready   = all_ready_q;
  assign error       = error_q;
  assign fault_stage = fault_stage_q;

endmodule
`default_nettype wire

// File: doc/rst_seq.md
# rst_seq

Parametrised multi-channel reset sequencer. It replaces the single-counter PLL-lock reset generator in the Glider top-level.
- Takes the PLL lock and per-stage "done" indications (e.g. MIG calibration, power-good).
- Releases N active-high reset outputs one at a time, in a fixed order.
- Applies a programmable settle delay before each release, with a timeout on each stage's acknowledge.
- Re-asserts every reset on loss of lock or on a software reset request from the CSR block.

## Interface

Parameters:
- CHANNELS, 4: number of sequenced reset outputs/stages (1..8).
- DELAY, 1024: cycles from entering a stage to releasing that stage's reset (≥1).
- TIMEOUT, 65536: cycles after a release within which stage_ok must arrive (≥1).
- LOCK_FILTER, 256: consecutive synchronised-high pll_locked samples required before sequencing starts (≥1).
- CW, derived: $clog2(max(DELAY,TIMEOUT,LOCK_FILTER)+1); counter width.
- SW, derived: max(1,$clog2(CHANNELS)); stage index width.

Ports:
- clk  input  1  system clock; all logic is in this domain.
- rst_n  input  1  asynchronous active-low reset.
- pll_locked  input  1  asynchronous; synchronised internally by a 2-flop synchroniser.
- stage_ok  input  CHANNELS  per-stage acknowledge; must be synchronous to clk (the caller synchronises it, e.g. with dff_sync).
- sw_reset  input  1  single-cycle restart request.
- rst_out  output  CHANNELS  active-high resets; bit i belongs to stage i.
- all_ready  output  1  high only in RUN.
- error  output  1  sticky stage-timeout flag.
- fault_stage  output  SW  index of the stage that timed out.

## Operation

States: LOCK_WAIT, STAGE, RUN, FAULT. Registers: stage index `s`, counter `cnt`, flag `released`.

Reset (rst_n low, asynchronous):
- state = LOCK_WAIT, cnt = 0, s = 0, released = 0.
- rst_out = all ones, all_ready = 0, error = 0, fault_stage = 0.
- Synchroniser flops cleared to 0.

LOCK_WAIT:
- cnt counts consecutive cycles with the synchronised lock high.
- Any low sample clears cnt.
- When cnt reaches LOCK_FILTER-1 with lock still high, go to STAGE with s = 0, cnt = 0, released = 0.

STAGE, released = 0:
- cnt increments each cycle.
- At cnt == DELAY-1: clear rst_out[s], set released = 1, cnt = 0.

STAGE, released = 1:
- If stage_ok[s] is high: if s == CHANNELS-1 go to RUN; otherwise s = s+1, cnt = 0, released = 0.
- Else if cnt == TIMEOUT-1: go to FAULT, error = 1, fault_stage = s.
- Otherwise cnt increments.

RUN:
- all_ready = 1; rst_out = 0.
- stage_ok is ignored in RUN.

FAULT:
- rst_out = all ones, all_ready = 0.
- Exited only by sw_reset, which goes to LOCK_WAIT and clears error and fault_stage.

Global aborts, evaluated before any state action:
- Synchronised lock low in STAGE or RUN: rst_out = all ones, all_ready = 0, go to LOCK_WAIT with cnt = 0. In FAULT, lock low does not change state.
- sw_reset in any state: rst_out = all ones, go to LOCK_WAIT with cnt = 0, clear error. sw_reset wins over lock loss; the resulting state is identical either way.
- The abort also overrides a release or advance scheduled for the same cycle.

Invariants:
- rst_out bits are released strictly in order 0..CHANNELS-1.
- A bit, once released, stays low until an abort or FAULT.
- rst_out[i] low implies rst_out[j] low for every j < i.

## Timing

- All outputs are registered. rst_out, all_ready, error and fault_stage change only on clk edges, except under rst_n assertion.
- Lock path: pll_locked rising to STAGE entry takes 2 + LOCK_FILTER cycles.
- Release: rst_out[s] falls exactly DELAY cycles after STAGE entry for s.
- Advance: stage_ok[s] sampled high at edge k means stage s+1 is entered at edge k and rst_out[s+1] falls at edge k+DELAY.
- RUN: all_ready rises on the same edge that RUN is entered.
- Lock-loss latency: pll_locked falling to rst_out all ones takes 3 cycles (2 synchroniser stages + 1 register).
- sw_reset latency: 1 cycle to rst_out all ones.
- Timeout: FAULT is entered TIMEOUT cycles after the release edge if stage_ok[s] stays low throughout.
- A stage_ok already high at release is accepted on the first cycle after release; the next stage is entered 1 cycle after the release.

## Test plan

All scenarios use CHANNELS=3, DELAY=4, LOCK_FILTER=8, TIMEOUT=16.

- Nominal bring-up: lock high at cycle 0, each stage_ok raised 2 cycles after its release.
  - rst_out[0] falls at cycle 14.
  - rst_out[1] falls at cycle 20.
  - rst_out[2] falls at cycle 26.
  - all_ready rises at cycle 28.
  - error stays 0.
- Lock glitch: lock high 6 cycles, low 1 cycle, then high again → filter restarts from 0 and rst_out[0] falls 14 cycles after the second rise.
- Lock loss in RUN: after bring-up, drop pll_locked → rst_out = 3'b111 and all_ready = 0 three cycles later. On relock the full sequence repeats with the same cycle offsets.
- Stage timeout: hold stage_ok[1] low → FAULT 16 cycles after rst_out[1] falls.
  - error = 1, fault_stage = 1, rst_out = 3'b111.
  - Relock does not leave FAULT.
  - A single sw_reset pulse clears error and restarts sequencing.
- Simultaneous events: assert sw_reset on the same cycle stage_ok[2] is high → RUN is never entered, rst_out = 3'b111, state is LOCK_WAIT.
- Async reset mid-sequence: pull rst_n low while in stage 1 → immediately rst_out = 3'b111, all_ready = 0, error = 0. After release, sequencing restarts from LOCK_WAIT.
